// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO widths and burst reader state encoding
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PTR   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 2-entry valid/ready buffer carrying {last, data}
module fifo_skid_buf #(
    parameter int WIDTH = fifo_pkg::FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       count
);

    logic [WIDTH:0] head;
    logic [WIDTH:0] tail;
    logic           pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head[WIDTH-1:0];
    assign out_last  = out_valid & head[WIDTH];

    // The writer never pushes into a full buffer without a simultaneous pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid) begin
                        head  <= {in_last, in_data};
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        head <= {in_last, in_data};
                    end else if (in_valid) begin
                        tail  <= {in_last, in_data};
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (in_valid) begin
                            tail <= {in_last, in_data};
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops the FIFO in bursts onto a valid/ready stream with last marker
module fifo_burst_reader #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::FIFO_DEPTH,
    parameter int FIFO_PTR   = fifo_pkg::FIFO_PTR,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_PTR:0]     fifo_data_avail,
    input  logic [FIFO_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [7:0]            burst_cnt
);
    import fifo_pkg::*;

    localparam int RW        = FIFO_PTR + 1;
    localparam int TW        = $clog2(TIMEOUT);
    localparam int BURST_EFF = (BURST_LEN > FIFO_DEPTH) ? FIFO_DEPTH : BURST_LEN;
    localparam logic [RW-1:0] BURST_W   = RW'(BURST_EFF);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic [RW-1:0] remaining;
    logic [RW-1:0] next_remaining;
    logic [TW-1:0] timer;
    logic [TW-1:0] next_timer;
    logic          inflight;
    logic          inflight_last;
    logic          burst_done;
    logic [1:0]    buf_count;
    logic [2:0]    occupancy;

    // Buffer slots still taken after this edge; a pop now needs one of two free next cycle.
    assign occupancy = {1'b0, buf_count} - {2'b0, out_valid & out_ready} + {2'b0, inflight};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining     <= '0;
            timer         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            burst_cnt     <= '0;
        end else begin
            remaining     <= next_remaining;
            timer         <= next_timer;
            inflight      <= fifo_rd_en;
            inflight_last <= fifo_rd_en && (remaining == RW'(1));
            burst_cnt     <= burst_cnt + {7'b0, burst_done};
        end
    end

    always_comb begin
        next_state     = state;
        next_remaining = remaining;
        next_timer     = '0;
        fifo_rd_en     = 1'b0;
        burst_done     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (fifo_data_avail >= BURST_W)) begin
                    next_remaining = BURST_W;
                    next_state     = READ;
                end else if (enable && (fifo_data_avail != '0)) begin
                    if (timer == TIMER_MAX) begin
                        next_remaining = fifo_data_avail;
                        next_state     = READ;
                    end else begin
                        next_timer = timer + TW'(1);
                    end
                end
            end
            READ: begin
                if (remaining == '0) begin
                    next_state = DRAIN;
                end else if (!fifo_empty && (occupancy < 3'd2)) begin
                    fifo_rd_en     = 1'b1;
                    next_remaining = remaining - RW'(1);
                end
            end
            DRAIN: begin
                if ((buf_count == 2'd0) && !inflight) begin
                    burst_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    fifo_skid_buf #(
        .WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (inflight),
        .in_data  (fifo_read_data),
        .in_last  (inflight_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [3:0]  fifo_data_avail;
    logic [15:0] fifo_read_data = '0;
    logic        fifo_rd_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic [7:0]  burst_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_burst_reader #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(8), .FIFO_PTR(3), .BURST_LEN(4), .TIMEOUT(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_data_avail(fifo_data_avail),
        .fifo_read_data (fifo_read_data),
        .fifo_rd_en     (fifo_rd_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .burst_cnt      (burst_cnt)
    );

    // Attached FIFO model: pop in cycle N, data on fifo_read_data in N+1
    logic        wr_en = 1'b0;
    logic        fifo_clr = 1'b1;
    logic [15:0] wr_data = '0;
    logic [15:0] fmem [8];
    logic [2:0]  wp = '0;
    logic [2:0]  rp = '0;
    logic [3:0]  fcnt = '0;
    int          empty_pops = 0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (wr_en) begin
                fmem[wp] <= wr_data;
                wp       <= wp + 3'd1;
            end
            if (fifo_rd_en) begin
                fifo_read_data <= fmem[rp];
                rp             <= rp + 3'd1;
                if (fcnt == 4'd0) empty_pops <= empty_pops + 1;
            end
            fcnt <= fcnt + {3'b0, wr_en} - {3'b0, fifo_rd_en};
        end
    end

    assign fifo_empty      = (fcnt == 4'd0);
    assign fifo_data_avail = fcnt;

    // Stream monitor, sampled mid-cycle
    logic        mon_clr = 1'b0;
    logic [15:0] got_data [$];
    logic        got_last [$];
    int          got_cyc [$];
    int          pops = 0;
    int          xfers = 0;
    int          stall_err = 0;
    int          ovf_err = 0;
    int          busy_rise = -1;
    int          first_valid = -1;
    logic        prev_stall = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_busy = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (mon_clr) begin
            got_data.delete();
            got_last.delete();
            got_cyc.delete();
            pops        = 0;
            xfers       = 0;
            busy_rise   = -1;
            first_valid = -1;
            prev_stall  = 1'b0;
            prev_busy   = busy;
        end else begin
            if (fifo_rd_en) begin
                if (pops - xfers > 2) ovf_err++;
                pops++;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
                xfers++;
            end
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (busy && !prev_busy) busy_rise = cyc;
            prev_busy = busy;
            if (out_valid && first_valid < 0) first_valid = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [15:0] first, input logic [15:0] stride, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            wr_en   = 1'b1;
            wr_data = 16'(first + i * stride);
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic clear_mon();
        step();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (got_data.size() >= n) && !busy;
        end
        chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    // Expected words follow first + i*stride; last sits on every 4th word and the final one
    task automatic check_words(input string tag, input logic [15:0] first, input logic [15:0] stride, input int n);
        logic [15:0] w;
        chk({tag, "_count"}, 32'(got_data.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            w = 16'(first + i * stride);
            chk($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(w));
            chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'((i % 4 == 3) || (i == n - 1)));
        end
    endtask

    initial begin
        int k;
        bit done;
        logic [3:0] pat;
        pat = 4'b1001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        reset    = 1'b1;
        fifo_clr = 1'b0;

        // Full burst at full rate
        write_words(16'h0011, 16'h0011, 4);
        clear_mon();
        step();
        k = cyc;
        enable    = 1'b1;
        out_ready = 1'b1;
        wait_done(4, 60, "full");
        check_words("full", 16'h0011, 16'h0011, 4);
        chk("full_pops", 32'(pops), 32'd4);
        chk("full_b2b", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
        chk("full_start", 32'(busy_rise - k), 32'd1);
        chk("full_latency", 32'(first_valid - busy_rise), 32'd2);
        chk("full_burst_cnt", 32'(burst_cnt), 32'd1);
        chk("full_avail", 32'(fifo_data_avail), 32'd0);
        enable = 1'b0;

        // Backpressure with ready pattern 1,0,0,1
        write_words(16'h0011, 16'h0011, 4);
        clear_mon();
        enable = 1'b1;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            out_ready = pat[i % 4];
            step();
            done = (got_data.size() >= 4) && !busy;
        end
        chk("bp_timeout", 32'(done), 32'd1);
        check_words("bp", 16'h0011, 16'h0011, 4);
        chk("bp_pops", 32'(pops), 32'd4);
        chk("bp_stable", 32'(stall_err), 32'd0);
        chk("bp_overflow", 32'(ovf_err), 32'd0);
        chk("bp_burst_cnt", 32'(burst_cnt), 32'd2);
        enable    = 1'b0;
        out_ready = 1'b1;

        // Partial residue flushed after TIMEOUT idle cycles
        write_words(16'h00A1, 16'h0001, 2);
        clear_mon();
        step();
        k = cyc;
        enable = 1'b1;
        wait_done(2, 60, "flush");
        chk("flush_delay", 32'(busy_rise - k), 32'd16);
        check_words("flush", 16'h00A1, 16'h0001, 2);
        chk("flush_pops", 32'(pops), 32'd2);
        chk("flush_avail", 32'(fifo_data_avail), 32'd0);
        chk("flush_burst_cnt", 32'(burst_cnt), 32'd3);
        enable = 1'b0;

        // Full FIFO drained as two back-to-back bursts
        write_words(16'h0101, 16'h0101, 8);
        clear_mon();
        enable = 1'b1;
        wait_done(8, 100, "cont");
        check_words("cont", 16'h0101, 16'h0101, 8);
        chk("cont_pops", 32'(pops), 32'd8);
        chk("cont_b2b_a", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
        chk("cont_b2b_b", 32'(got_cyc[7] - got_cyc[4]), 32'd3);
        chk("cont_burst_cnt", 32'(burst_cnt), 32'd5);
        chk("cont_empty", 32'(fifo_empty), 32'd1);
        chk("cont_empty_pops", 32'(empty_pops), 32'd0);
        chk("cont_overflow", 32'(ovf_err), 32'd0);
        enable = 1'b0;

        // Enable dropped in the 2nd READ cycle: burst completes, none follows
        write_words(16'h5001, 16'h0001, 8);
        clear_mon();
        enable = 1'b1;
        step();
        step();
        chk("drop_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_done(4, 60, "drop");
        repeat (30) step();
        check_words("drop", 16'h5001, 16'h0001, 4);
        chk("drop_pops", 32'(pops), 32'd4);
        chk("drop_idle", 32'(busy), 32'd0);
        chk("drop_avail", 32'(fifo_data_avail), 32'd4);
        chk("drop_burst_cnt", 32'(burst_cnt), 32'd6);

        // Asynchronous reset while a stalled burst holds data
        out_ready = 1'b0;
        enable    = 1'b1;
        repeat (6) step();
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_data", 32'(out_data), 32'h5005);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_burst_cnt", 32'(burst_cnt), 32'd0);
        enable = 1'b0;
        step();
        reset = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO: watches its occupancy, pops words in fixed-size bursts and presents them on a valid/ready stream with a last-word marker.
- A partial burst is flushed when a short residue sits in the FIFO for too long.
- Sits between the FIFO read port and any downstream consumer (serializer, bus writer).
- Matches FIFO read timing: read strobe in cycle N, data on fifo_read_data in cycle N+1.

Parameters:
- FIFO_WIDTH, 16, data word width.
- FIFO_DEPTH, 8, depth of the attached FIFO.
- FIFO_PTR, 3, log2(FIFO_DEPTH); occupancy input is FIFO_PTR+1 bits.
- BURST_LEN, 4, words per full burst, 1..FIFO_DEPTH.
- TIMEOUT, 16, idle cycles before a partial burst is flushed, >=2.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits starting new bursts; an ongoing burst always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_avail  input  FIFO_PTR+1  FIFO occupancy.
- fifo_read_data  input  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO pop strobe.
- out_data  output  FIFO_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from consumer.
- out_last  output  1  marks the final word of a burst.
- busy  output  1  high whenever state is not IDLE.
- burst_cnt  output  8  count of completed bursts, wraps 255->0.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all outputs 0; internal counters 0; skid buffer empty.
- States: IDLE, READ, DRAIN.
- IDLE, full-burst start: if enable=1 and fifo_data_avail >= BURST_LEN, latch remaining=BURST_LEN and go to READ.
- IDLE, flush timer:
  - Counts while enable=1 and 0 < fifo_data_avail < BURST_LEN; otherwise clears to 0.
  - When it reaches TIMEOUT-1 under that condition: latch remaining=fifo_data_avail, clear the timer, go to READ.
- READ, pop rule: fifo_rd_en=1 iff remaining>0 AND fifo_empty=0 AND (buffered words + in-flight read) < 2.
  - Each pop decrements remaining.
  - fifo_rd_en is never asserted while fifo_empty=1.
- READ, exit: go to DRAIN in the cycle after remaining reaches 0.
- Buffering: 2-entry output buffer (skid).
  - The word returned at N+1 is written into the buffer.
  - Head of the buffer drives out_data/out_valid.
  - A word leaves on out_valid & out_ready.
  - Capacity accounting makes overflow impossible when out_ready stalls.
- out_last: tagged on the word popped when remaining goes 1->0, carried with that word through the buffer.
- Stream rules:
  - out_data/out_valid/out_last are held stable while out_valid=1 and out_ready=0.
  - Back-to-back transfers at 1 word/cycle when out_ready is held high: throughput 1/cycle after the first word.
  - Latency from burst start to first out_valid: 2 cycles.
- DRAIN: when the buffer is empty and no read is in flight, increment burst_cnt and return to IDLE; a new burst may start the following cycle.
- Disable mid-burst: enable=0 during READ/DRAIN has no effect on the current burst; it only blocks the next start.
- Reset mid-burst: abandons the burst immediately; words already popped are lost; burst_cnt returns to 0.
- Widths:
  - remaining is FIFO_PTR+1 bits.
  - Timer is clog2(TIMEOUT) bits and saturates at TIMEOUT-1.
  - Comparisons are unsigned.

Decomposition:
- Shared package fifo_pkg: FIFO_WIDTH/FIFO_DEPTH/FIFO_PTR defaults and the state encoding constants (IDLE=2'd0, READ=2'd1, DRAIN=2'd2).
- One natural sub-module: fifo_skid_buf, the 2-entry valid/ready buffer carrying {last, data}. Its ports: clk, reset, in_valid, in_data, in_last, out_valid, out_ready, out_data, out_last, count[1:0].
- FSM, counters and pop logic stay in the top module.

Test Plan:
- Full burst: reset, write 0x0011,0x0022,0x0033,0x0044 into the attached FIFO, enable=1, out_ready=1 -> four fifo_rd_en pulses; out_data 0x0011..0x0044 on consecutive cycles; out_last only on 0x0044; burst_cnt=1.
- Backpressure: same data, out_ready toggling 1,0,0,1,... -> no word lost or duplicated, outputs stable while stalled, fifo_rd_en never pops beyond buffer space, order preserved.
- Partial flush: write 2 words (0x00A1,0x00A2), hold them -> after 16 idle cycles, 2 pops; out_last on 0x00A2; fifo_data_avail returns to 0.
- Full FIFO, continuous: preload 8 words, out_ready=1 -> two bursts of 4 back-to-back, out_last on the 4th and 8th words, burst_cnt=2, fifo_empty=1 at end with no pop while empty.
- Enable drop and reset: drop enable in the 2nd cycle of READ -> the burst completes, no new burst starts. Assert reset mid-burst -> all outputs 0 asynchronously, busy=0, burst_cnt=0.
